bitserial_operand_feeder: RTL and testbench



---
 rtl/bitserial_operand_feeder.sv | 157 +++++++++++++++
 tb/tb_bitserial_operand_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitserial_operand_feeder.sv
// Sequencer for the bit-serial MAC: buffers activation/weight pairs and holds each one
// on the MAC for eight enabled cycles. It also issues the MAC clear and the final flush cycle.
`timescale 1ns/1ps
module bitserial_operand_feeder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [1:0]       prec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_act,
  input  logic [7:0]       in_wgt,
  output logic [7:0]       mac_act,
  output logic [7:0]       mac_wgt,
  output logic             mac_en,
  output logic             mac_rstn,
  output logic [1:0]       mac_prec,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             vec_done
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StClear, StRun, StFlush, StDone} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       act_q, act_d, wgt_q, wgt_d;
  logic             en_q, en_d, rstn_q, rstn_d, done_q, done_d;
  logic [1:0]       prec_q, prec_d;
  logic [2:0]       phase_q, phase_d;

  // FIFO storage; pointers carry one extra bit to tell full from empty.
  logic [7:0]   mem_act [DEPTH];
  logic [7:0]   mem_wgt [DEPTH];
  logic [PTR_W:0] wr_ptr_q, rd_ptr_q;
  logic           fifo_empty, fifo_full, push, pop, boundary;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_act[wr_ptr_q[PTR_W-1:0]] <= in_act;
      mem_wgt[wr_ptr_q[PTR_W-1:0]] <= in_wgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // A pair boundary is the edge leaving CLEAR, the last phase of a pair, or any stalled cycle.
  assign boundary = (state_q == StClear) ||
                    ((state_q == StRun) && (!en_q || (phase_q == 3'd7)));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    act_d   = act_q;
    wgt_d   = wgt_q;
    en_d    = 1'b0;
    rstn_d  = 1'b1;
    done_d  = 1'b0;
    prec_d  = prec_q;
    phase_d = phase_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && (vec_len != '0)) begin
          state_d = StClear;
          rem_d   = vec_len;
          prec_d  = prec;
          rstn_d  = 1'b0;
          phase_d = 3'd0;
        end
      end
      StClear, StRun: begin
        if (boundary) begin
          state_d = StRun;
          phase_d = 3'd0;
          if (rem_q == '0) begin
            state_d = StFlush;
            en_d    = 1'b1;
            act_d   = 8'd0;
            wgt_d   = 8'd0;
          end else if (!fifo_empty) begin
            pop   = 1'b1;
            act_d = mem_act[rd_ptr_q[PTR_W-1:0]];
            wgt_d = mem_wgt[rd_ptr_q[PTR_W-1:0]];
            en_d  = 1'b1;
            rem_d = rem_q - LEN_W'(1);
          end
        end else begin
          en_d    = 1'b1;
          phase_d = phase_q + 3'd1;
        end
      end
      StFlush: begin
        // The flush cycle advances the MAC counter 0->1 like any enabled cycle.
        state_d = StDone;
        phase_d = phase_q + 3'd1;
        done_d  = 1'b1;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      act_q   <= 8'd0;
      wgt_q   <= 8'd0;
      en_q    <= 1'b0;
      rstn_q  <= 1'b0;
      done_q  <= 1'b0;
      prec_q  <= 2'd0;
      phase_q <= 3'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      act_q   <= act_d;
      wgt_q   <= wgt_d;
      en_q    <= en_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      prec_q  <= prec_d;
      phase_q <= phase_d;
    end
  end

  assign mac_act  = act_q;
  assign mac_wgt  = wgt_q;
  assign mac_en   = en_q;
  assign mac_rstn = rstn_q;
  assign mac_prec = prec_q;
  assign phase    = phase_q;
  assign busy     = (state_q != StIdle);
  assign vec_done = done_q;

endmodule

// File: tb/tb_bitserial_operand_feeder.sv
// Directed bench for bitserial_operand_feeder: timing, stalls, FIFO full, ignored starts, reset.
`timescale 1ns/1ps
module tb_bitserial_operand_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] vec_len = 8'd0;
  logic [1:0] prec = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_act = 8'd0;
  logic [7:0] in_wgt = 8'd0;
  logic [7:0] mac_act, mac_wgt;
  logic       mac_en, mac_rstn, busy, vec_done;
  logic [1:0] mac_prec;
  logic [2:0] phase;

  bitserial_operand_feeder #(.DEPTH(4), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .prec(prec),
    .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt),
    .mac_act(mac_act), .mac_wgt(mac_wgt), .mac_en(mac_en), .mac_rstn(mac_rstn),
    .mac_prec(mac_prec), .phase(phase), .busy(busy), .vec_done(vec_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Results gathered by run_vec
  int         first_en, last_en, en_cnt, gap_cnt, gap_phase_bad, done_cyc, prec_bad, npairs;
  int         dot;
  int         pstart [4];
  logic [7:0] pacts [4];
  logic [7:0] pwgts [4];
  logic       clr_rstn, clr_en, rdy1, rdy2;
  logic [19:0] res20;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_pair(input logic [7:0] a, input logic [7:0] w);
    in_valid = 1'b1;
    in_act   = a;
    in_wgt   = w;
    tick();
    in_valid = 1'b0;
  endtask

  // Starts a vector and observes it cycle by cycle (cycle 1 = cycle after the start edge).
  task automatic run_vec(input logic [7:0] len, input logic [1:0] p, input int push_cyc,
                         input logic [7:0] pa, input logic [7:0] pw, input int restart_cyc);
    first_en = -1; last_en = -1; en_cnt = 0; gap_cnt = 0; gap_phase_bad = 0;
    done_cyc = -1; prec_bad = 0; npairs = 0; dot = 0;
    for (int k = 0; k < 4; k++) begin
      pstart[k] = -1; pacts[k] = 8'hxx; pwgts[k] = 8'hxx;
    end
    start = 1'b1; vec_len = len; prec = p;
    tick();
    start = 1'b0;
    clr_rstn = mac_rstn; clr_en = mac_en; rdy1 = in_ready;
    if (mac_prec !== p) prec_bad++;
    for (int c = 2; c < 80; c++) begin
      tick();
      start    = (c == restart_cyc);
      vec_len  = (c == restart_cyc) ? 8'd3 : len;
      prec     = (c == restart_cyc) ? 2'b11 : p;
      in_valid = (c == push_cyc);
      in_act   = pa;
      in_wgt   = pw;
      if (c == 2) rdy2 = in_ready;
      if (mac_prec !== p) prec_bad++;
      if (vec_done) begin
        done_cyc = c;
        break;
      end
      if (mac_en) begin
        if (first_en < 0) first_en = c;
        last_en = c;
        en_cnt++;
        if (phase == 3'd0) begin
          dot += int'($signed(mac_act)) * int'($signed(mac_wgt));
          if (npairs < 4 && npairs < int'(len)) begin
            pstart[npairs] = c; pacts[npairs] = mac_act; pwgts[npairs] = mac_wgt;
          end
          npairs++;
        end
      end else if (first_en >= 0) begin
        gap_cnt++;
        if (phase != 3'd0) gap_phase_bad++;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    res20 = dot[19:0];
  endtask

  int cnt;

  initial begin
    // Reset state while rst is held
    tick(); tick();
    check("rst_mac_act", 32'(mac_act), 32'h0);
    check("rst_mac_wgt", 32'(mac_wgt), 32'h0);
    check("rst_mac_en", 32'(mac_en), 32'h0);
    check("rst_mac_rstn", 32'(mac_rstn), 32'h0);
    check("rst_mac_prec", 32'(mac_prec), 32'h0);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_vec_done", 32'(vec_done), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    rst = 1'b0;
    tick();
    check("idle_mac_rstn", 32'(mac_rstn), 32'h1);

    // Back-to-back pairs from a pre-filled FIFO
    push_pair(8'h67, 8'h0A);
    push_pair(8'h3F, 8'hE1);
    run_vec(8'd2, 2'b00, 0, 8'h00, 8'h00, 0);
    check("a_clear_rstn", 32'(clr_rstn), 32'h0);
    check("a_clear_en", 32'(clr_en), 32'h0);
    check("a_first_en", 32'(first_en), 32'd2);
    check("a_last_en", 32'(last_en), 32'd18);
    check("a_en_cnt", 32'(en_cnt), 32'd17);
    check("a_pair2_start", 32'(pstart[1]), 32'd10);
    check("a_gap", 32'(gap_cnt), 32'd0);
    check("a_done_cyc", 32'(done_cyc), 32'd19);
    check("a_result", 32'(res20), 32'hFFC65);
    tick();
    check("a_busy_after", 32'(busy), 32'h0);
    check("a_done_pulse", 32'(vec_done), 32'h0);

    // Second pair arrives late: pushed during cycle 13, so cycles 10..14 stall
    push_pair(8'h67, 8'h0A);
    run_vec(8'd2, 2'b00, 13, 8'h3F, 8'hE1, 0);
    check("b_gap", 32'(gap_cnt), 32'd5);
    check("b_gap_phase", 32'(gap_phase_bad), 32'd0);
    check("b_pair2_start", 32'(pstart[1]), 32'd15);
    check("b_en_cnt", 32'(en_cnt), 32'd17);
    check("b_done_cyc", 32'(done_cyc), 32'd24);
    check("b_result", 32'(res20), 32'hFFC65);
    tick();

    // FIFO full while idle; an extra offer must be refused
    push_pair(8'h11, 8'h01);
    push_pair(8'h22, 8'h02);
    push_pair(8'h33, 8'h03);
    check("c_ready_before_full", 32'(in_ready), 32'h1);
    push_pair(8'h44, 8'h04);
    check("c_full_ready", 32'(in_ready), 32'h0);
    push_pair(8'h99, 8'h09);
    check("c_full_ready_hold", 32'(in_ready), 32'h0);
    run_vec(8'd4, 2'b01, 0, 8'h00, 8'h00, 0);
    check("c_ready_cyc1", 32'(rdy1), 32'h0);
    check("c_ready_cyc2", 32'(rdy2), 32'h1);
    check("c_act0", 32'(pacts[0]), 32'h11);
    check("c_act1", 32'(pacts[1]), 32'h22);
    check("c_act2", 32'(pacts[2]), 32'h33);
    check("c_act3", 32'(pacts[3]), 32'h44);
    check("c_wgt3", 32'(pwgts[3]), 32'h04);
    check("c_done_cyc", 32'(done_cyc), 32'd35);
    tick();

    // start with vec_len=0 is ignored
    start = 1'b1; vec_len = 8'd0; prec = 2'b11;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy || vec_done || !mac_rstn) cnt++;
      tick();
    end
    check("d_len0_ignored", 32'(cnt), 32'd0);
    check("d_len0_prec", 32'(mac_prec), 32'h1);

    // Precision 10, one pair, with a second start during RUN
    push_pair(8'h5C, 8'h4E);
    run_vec(8'd1, 2'b10, 0, 8'h00, 8'h00, 5);
    check("e_prec", 32'(prec_bad), 32'd0);
    check("e_en_cnt", 32'(en_cnt), 32'd9);
    check("e_done_cyc", 32'(done_cyc), 32'd11);
    check("e_act", 32'(pacts[0]), 32'h5C);
    check("e_wgt", 32'(pwgts[0]), 32'h4E);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy || vec_done) cnt++;
    end
    check("e_restart_ignored", 32'(cnt), 32'd0);

    // Reset in the middle of RUN, leaving one pair in the FIFO
    push_pair(8'h12, 8'h34);
    push_pair(8'h56, 8'h78);
    start = 1'b1; vec_len = 8'd1; prec = 2'b01;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("f_running", 32'(mac_en), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("f_rst_en", 32'(mac_en), 32'h0);
    check("f_rst_rstn", 32'(mac_rstn), 32'h0);
    check("f_rst_act", 32'(mac_act), 32'h0);
    check("f_rst_prec", 32'(mac_prec), 32'h0);
    check("f_rst_phase", 32'(phase), 32'h0);
    check("f_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("f_ready_after", 32'(in_ready), 32'h1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (vec_done) cnt++;
    end
    check("f_no_done", 32'(cnt), 32'd0);
    // FIFO was emptied: a new vector must stall with mac_en low
    start = 1'b1; vec_len = 8'd1; prec = 2'b00;
    tick();
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mac_en) cnt++;
    end
    check("f_fifo_emptied", 32'(cnt), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
